// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks in-flight writes per register, stalls decode on
// RAW hazards or counter saturation, and drains the pipeline on halt request.
module reg_scoreboard #(
  parameter int unsigned MAXPEND = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        d_valid,
  input  logic [3:0]  d_srcA,
  input  logic [3:0]  d_srcB,
  input  logic [3:0]  d_dstE,
  input  logic [3:0]  d_dstM,
  input  logic        w_valid,
  input  logic [3:0]  w_dstE,
  input  logic [3:0]  w_dstM,
  input  logic        k_valid,
  input  logic [3:0]  k_dstE,
  input  logic [3:0]  k_dstM,
  input  logic        halt_req,
  output logic        d_stall,
  output logic        d_issue,
  output logic [14:0] pending,
  output logic [1:0]  state,
  output logic        drained,
  output logic        err
);

  localparam int unsigned CW = $clog2(MAXPEND + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    BAD    = 2'd3
  } state_e;

  logic [CW-1:0] cnt_q [15];
  logic [CW-1:0] cnt_d [15];
  logic [CW:0]   sum_w [15];
  logic [1:0]    dec_w [15];
  state_e        state_q, state_d;
  logic          err_q, err_d;
  logic [15:0]   busy, full;
  logic          hazard, overflow, underflow, all_zero_d;

  // Bit 15 stays 0 so that ID 4'hF never hits a hazard or overflow.
  always_comb begin
    busy = '0;
    full = '0;
    for (int unsigned i = 0; i < 15; i++) begin
      busy[i] = (cnt_q[i] != '0);
      full[i] = (cnt_q[i] == CW'(MAXPEND));
    end
  end

  assign hazard   = busy[d_srcA] | busy[d_srcB];
  assign overflow = full[d_dstE] | full[d_dstM];
  assign d_stall  = d_valid & (hazard | overflow | (state_q != RUN));
  assign d_issue  = d_valid & ~d_stall;

  // A pair naming the same register counts once; decrements below zero clamp.
  always_comb begin
    underflow  = 1'b0;
    all_zero_d = 1'b1;
    for (int unsigned i = 0; i < 15; i++) begin
      sum_w[i] = {1'b0, cnt_q[i]}
               + (CW+1)'(d_issue & ((d_dstE == 4'(i)) | (d_dstM == 4'(i))));
      dec_w[i] = {1'b0, w_valid & ((w_dstE == 4'(i)) | (w_dstM == 4'(i)))}
               + {1'b0, k_valid & ((k_dstE == 4'(i)) | (k_dstM == 4'(i)))};
      if ((CW+1)'(dec_w[i]) > sum_w[i]) begin
        cnt_d[i]  = '0;
        underflow = 1'b1;
      end else begin
        cnt_d[i] = CW'(sum_w[i] - (CW+1)'(dec_w[i]));
      end
      if (cnt_d[i] != '0) all_zero_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q | underflow;
    case (state_q)
      RUN:     if (halt_req) state_d = DRAIN;
      DRAIN:   if (all_zero_d) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 15; i++) cnt_q[i] <= '0;
      state_q <= RUN;
      err_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 15; i++) cnt_q[i] <= cnt_d[i];
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign pending = busy[14:0];
  assign state   = state_q;
  assign drained = (state_q == HALTED);
  assign err     = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench: a per-register pending-count model predicts every cycle's
// outputs into a queue; a negedge monitor pops and compares against the DUT.
module tb_reg_scoreboard;

  localparam int MAXPEND = 3;
  localparam int F = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        d_valid = 1'b0, w_valid = 1'b0, k_valid = 1'b0, halt_req = 1'b0;
  logic [3:0]  d_srcA = 4'hF, d_srcB = 4'hF, d_dstE = 4'hF, d_dstM = 4'hF;
  logic [3:0]  w_dstE = 4'hF, w_dstM = 4'hF, k_dstE = 4'hF, k_dstM = 4'hF;
  logic        d_stall, d_issue, drained, err;
  logic [14:0] pending;
  logic [1:0]  state;

  reg_scoreboard #(.MAXPEND(MAXPEND)) dut (
    .clk(clk), .rst_n(rst_n), .d_valid(d_valid),
    .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dstE(d_dstE), .d_dstM(d_dstM),
    .w_valid(w_valid), .w_dstE(w_dstE), .w_dstM(w_dstM),
    .k_valid(k_valid), .k_dstE(k_dstE), .k_dstM(k_dstM),
    .halt_req(halt_req), .d_stall(d_stall), .d_issue(d_issue),
    .pending(pending), .state(state), .drained(drained), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        issue;
    logic [14:0] pend;
    logic [1:0]  st;
    logic        drn;
    logic        er;
  } exp_t;

  exp_t q[$];
  exp_t m;
  int   n_chk = 0;
  int   n_fail = 0;

  // Reference model: pending writes per register, mode 0=run 1=drain 2=halted.
  int   cnt_m [15];
  int   mode_m;
  bit   err_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      m = q.pop_front();
      chk("d_stall", 32'(d_stall), 32'(m.stall));
      chk("d_issue", 32'(d_issue), 32'(m.issue));
      chk("pending", 32'(pending), 32'(m.pend));
      chk("state",   32'(state),   32'(m.st));
      chk("drained", 32'(drained), 32'(m.drn));
      chk("err",     32'(err),     32'(m.er));
    end
  end

  task automatic model_clear();
    for (int i = 0; i < 15; i++) cnt_m[i] = 0;
    mode_m = 0;
    err_m  = 1'b0;
  endtask

  function automatic bit hits(int a, int b, int i);
    return (a == i) || (b == i);
  endfunction

  task automatic drive(input bit dv, input int sA, input int sB, input int dE, input int dM,
                       input bit wv, input int wE, input int wM,
                       input bit kv, input int kE, input int kM, input bit hr);
    exp_t e;
    bit   hz, ov, all_zero;
    int   n;
    d_valid = dv; d_srcA = 4'(sA); d_srcB = 4'(sB); d_dstE = 4'(dE); d_dstM = 4'(dM);
    w_valid = wv; w_dstE = 4'(wE); w_dstM = 4'(wM);
    k_valid = kv; k_dstE = 4'(kE); k_dstM = 4'(kM);
    halt_req = hr;
    hz = (sA != F && cnt_m[sA] > 0) || (sB != F && cnt_m[sB] > 0);
    ov = (dE != F && cnt_m[dE] == MAXPEND) || (dM != F && cnt_m[dM] == MAXPEND);
    e.stall = dv && (hz || ov || mode_m != 0);
    e.issue = dv && !e.stall;
    for (int i = 0; i < 15; i++) e.pend[i] = (cnt_m[i] != 0);
    e.st  = 2'(mode_m);
    e.drn = (mode_m == 2);
    e.er  = err_m;
    q.push_back(e);
    all_zero = 1'b1;
    for (int i = 0; i < 15; i++) begin
      n = cnt_m[i];
      if (e.issue && hits(dE, dM, i)) n++;
      if (wv && hits(wE, wM, i)) n--;
      if (kv && hits(kE, kM, i)) n--;
      if (n < 0) begin
        n = 0;
        err_m = 1'b1;
      end
      cnt_m[i] = n;
      if (n != 0) all_zero = 1'b0;
    end
    if (mode_m == 0 && hr) mode_m = 1;
    else if (mode_m == 1 && all_zero) mode_m = 2;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, F, F, F, F, 0, F, F, 0, F, F, 0);
  endtask

  // Reset takes effect immediately, without waiting for a clock edge.
  task automatic do_reset();
    d_valid = 1'b0; w_valid = 1'b0; k_valid = 1'b0; halt_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_state",   32'(state),   32'd0);
    chk("rst_err",     32'(err),     32'd0);
    chk("rst_drained", 32'(drained), 32'd0);
    chk("rst_stall",   32'(d_stall), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int rid();
    int r = int'($urandom_range(0, 7));
    return (r < 6) ? r : F;
  endfunction

  function automatic int pick_busy();
    int c[$];
    for (int i = 0; i < 15; i++) if (cnt_m[i] > 0) c.push_back(i);
    if (c.size() == 0 || $urandom_range(0, 19) == 0) return rid();
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  initial begin
    int wE, kE;
    do_reset();

    // RAW hazard on r3 cleared one cycle after writeback.
    drive(1, F, F, 3, F, 0, F, F, 0, F, F, 0);
    drive(1, 3, F, F, F, 0, F, F, 0, F, F, 0);
    drive(1, 3, F, F, F, 1, 3, F, 0, F, F, 0);
    drive(1, 3, F, F, F, 0, F, F, 0, F, F, 0);

    // Saturation on r2, then one retire frees a slot.
    repeat (3) drive(1, F, F, 2, F, 0, F, F, 0, F, F, 0);
    drive(1, F, F, 2, F, 0, F, F, 0, F, F, 0);
    drive(1, F, F, 2, F, 1, 2, F, 0, F, F, 0);
    drive(1, F, F, 2, F, 0, F, F, 0, F, F, 0);
    repeat (3) drive(0, F, F, F, F, 1, 2, F, 0, F, F, 0);

    // Same-cycle issue and retire on r5 nets to no change.
    drive(1, F, F, 5, F, 0, F, F, 0, F, F, 0);
    drive(1, F, F, 5, F, 1, 5, F, 0, F, F, 0);
    drive(0, F, F, F, F, 1, 5, F, 0, F, F, 0);

    // popq %rsp: one pending write on r4, extra retire underflows.
    drive(1, F, F, 4, 4, 0, F, F, 0, F, F, 0);
    drive(0, F, F, F, F, 1, 4, 4, 0, F, F, 0);
    drive(0, F, F, F, F, 1, 4, F, 0, F, F, 0);
    idle();
    idle();
    do_reset();

    // Halt with r1, r7 outstanding; retire and squash drain to HALTED.
    drive(1, F, F, 1, F, 0, F, F, 0, F, F, 0);
    drive(1, F, F, 7, F, 0, F, F, 0, F, F, 1);
    drive(1, F, F, F, F, 0, F, F, 0, F, F, 0);
    drive(0, F, F, F, F, 1, 1, F, 1, 7, F, 0);
    drive(1, F, F, F, F, 0, F, F, 0, F, F, 0);
    idle();

    // Reset in the middle of a drain.
    do_reset();
    drive(1, F, F, 3, F, 0, F, F, 0, F, F, 1);
    idle();
    do_reset();

    // Halt with nothing outstanding reaches HALTED one cycle after DRAIN.
    drive(0, F, F, F, F, 0, F, F, 0, F, F, 1);
    idle();
    idle();
    do_reset();

    for (int ep = 0; ep < 4; ep++) begin
      for (int c = 0; c < 400; c++) begin
        wE = pick_busy();
        kE = pick_busy();
        drive($urandom_range(0, 3) != 0, rid(), rid(), rid(),
              ($urandom_range(0, 3) == 0) ? rid() : F,
              $urandom_range(0, 2) == 0, wE, ($urandom_range(0, 5) == 0) ? wE : F,
              $urandom_range(0, 6) == 0, kE, F,
              (c > 100) && ($urandom_range(0, 149) == 0));
      end
      do_reset();
    end

    @(negedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
